chirp_uart_rx: RTL and testbench

//  UART 8N1 receiver feeding the chirp generator's configuration path. Samples the

---
 rtl/chirp_uart_rx.sv | 134 +++++++++++++
 tb/tb_chirp_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/chirp_uart_rx.sv
// chirp_uart_rx: UART receiver with 3-sample majority voting; optional even parity via CHIRP_UART_PARITY_EN
module chirp_uart_rx #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_frame_err,
    output logic                  o_parity_err,
    output logic                  o_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int IW           = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] C_H0  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_H1  = CW'(HALF);
    localparam logic [CW-1:0] C_H2  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
`ifdef CHIRP_UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif
    logic [2:0]            state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  rx_m, rx_s, rx_d;
    logic                  s0, s1;
    logic                  maj;
    logic                  perr;
    assign maj    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign o_busy = state != IDLE;
`ifdef CHIRP_UART_PARITY_EN
    logic par_bit;
    assign perr = ^{shreg, par_bit};
    always_ff @(posedge i_clk) begin
        if (i_rst)
            par_bit <= 1'b0;
        else if (state == PARITY && cnt == C_H2)
            par_bit <= maj;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_parity_err <= 1'b0;
        else
            o_parity_err <= state == STOP && cnt == C_H2 && perr;
    end
`else
    assign perr         = 1'b0;
    assign o_parity_err = 1'b0;
`endif
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            rx_d        <= 1'b1;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_m        <= i_rx;
            rx_s        <= rx_m;
            rx_d        <= rx_s;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            cnt         <= (cnt == C_END) ? '0 : cnt + CW'(1);
            if (cnt == C_H0)
                s0 <= rx_s;
            if (cnt == C_H1)
                s1 <= rx_s;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_d && !rx_s)
                        state <= START;
                end
                START: begin
                    if (cnt == C_H2 && maj)
                        state <= IDLE;
                    else if (cnt == C_END) begin
                        state <= DATA;
                        idx   <= '0;
                    end
                end
                DATA: begin
                    if (cnt == C_H2)
                        shreg <= {maj, shreg[DATA_WIDTH-1:1]};
                    if (cnt == C_END) begin
                        idx <= idx + IW'(1);
`ifdef CHIRP_UART_PARITY_EN
                        if (idx == I_LAST)
                            state <= PARITY;
`else
                        if (idx == I_LAST)
                            state <= STOP;
`endif
                    end
                end
`ifdef CHIRP_UART_PARITY_EN
                PARITY: begin
                    if (cnt == C_END)
                        state <= STOP;
                end
`endif
                STOP: begin
                    // leave half a bit early so the next start edge is never missed
                    if (cnt == C_H2) begin
                        state       <= IDLE;
                        o_valid     <= maj && !perr;
                        o_frame_err <= !maj;
                        if (maj && !perr)
                            o_data <= shreg;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chirp_uart_rx.sv
// tb_chirp_uart_rx: scoreboard bench for chirp_uart_rx at 1041 clocks per bit
module tb_chirp_uart_rx;
    localparam int CPB = 1041;
`ifdef CHIRP_UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_parity_err, o_busy;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;
    int         n_ferr   = 0;
    int         n_perr   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    chirp_uart_rx dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_rx(rx),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_frame_err(o_frame_err),
        .o_parity_err(o_parity_err),
        .o_busy(o_busy)
    );

    always #50 clk = ~clk;

    initial begin
        #(64'd200_000 * 100);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (o_frame_err)
            n_ferr++;
        if (o_parity_err)
            n_perr++;
        if (o_valid) begin
            n_valid++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: got byte %02h, expected none", o_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (o_data !== exp_b || o_frame_err || o_parity_err) begin
                    n_fail++;
                    $display("FAIL scoreboard: got %02h ferr=%0b perr=%0b, expected %02h no errors",
                             o_data, o_frame_err, o_parity_err, exp_b);
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        clks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++)
            bit_out(b[i]);
        if (PAR)
            bit_out(^b ^ ~par_ok);
        bit_out(stop);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clks(4);
        n_checks += 5;
        if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, expected 00", o_data); end
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, expected 0", o_valid); end
        if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %0b, expected 0", o_frame_err); end
        if (o_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %0b, expected 0", o_parity_err); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, expected 0", o_busy); end
        rst = 1'b0;
        clks(20);
    endtask

    task automatic test_single;
        int v0 = n_valid, f0 = n_ferr, p0 = n_perr;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        clks(20);
        n_checks += 5;
        if (n_valid !== v0 + 1) begin n_fail++; $display("FAIL single_valid_count: got %0d, expected %0d", n_valid - v0, 1); end
        if (n_ferr !== f0 || n_perr !== p0) begin n_fail++; $display("FAIL single_errors: got ferr %0d perr %0d, expected 0 0", n_ferr - f0, n_perr - p0); end
        if (o_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %02h, expected a5", o_data); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %0b, expected 0", o_busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_queue: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h55};
        int v0 = n_valid, f0 = n_ferr;
        foreach (bytes[i]) begin
            exp_q.push_back(bytes[i]);
            send_frame(bytes[i], 1'b1, 1'b1);
        end
        clks(20);
        n_checks += 4;
        if (n_valid !== v0 + 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d, expected 3", n_valid - v0); end
        if (n_ferr !== f0) begin n_fail++; $display("FAIL b2b_ferr: got %0d, expected 0", n_ferr - f0); end
        if (o_data !== 8'h55) begin n_fail++; $display("FAIL b2b_last_data: got %02h, expected 55", o_data); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_glitch;
        int v0 = n_valid, f0 = n_ferr, p0 = n_perr;
        bit went = 1'b0, done = 1'b0;
        int low_at = 0;
        rx = 1'b0;
        for (int i = 1; i <= 700 && !done; i++) begin
            @(negedge clk);
            if (i == 200)
                rx = 1'b1;
            if (o_busy)
                went = 1'b1;
            else if (went) begin
                done   = 1'b1;
                low_at = i;
            end
        end
        rx = 1'b1;
        clks(20);
        n_checks += 3;
        if (!went || !done) begin n_fail++; $display("FAIL glitch_busy_seen: got went=%0b done=%0b, expected 1 1", went, done); end
        if (low_at < 520 || low_at > 530) begin n_fail++; $display("FAIL glitch_busy_drop: got cycle %0d, expected 520..530", low_at); end
        if (n_valid !== v0 || n_ferr !== f0 || n_perr !== p0) begin n_fail++; $display("FAIL glitch_pulses: got v%0d f%0d p%0d, expected 0 0 0", n_valid - v0, n_ferr - f0, n_perr - p0); end
    endtask

    task automatic test_frame_err;
        int v0 = n_valid, f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b0;
        clks(CPB);
        n_checks += 4;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL break_no_retrigger: got busy %0b, expected 0", o_busy); end
        if (n_ferr !== f0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d, expected 1", n_ferr - f0); end
        if (n_valid !== v0) begin n_fail++; $display("FAIL ferr_valid: got %0d, expected 0", n_valid - v0); end
        if (o_data !== 8'h55) begin n_fail++; $display("FAIL ferr_data_held: got %02h, expected 55", o_data); end
        rx = 1'b1;
        clks(50);
    endtask

    task automatic test_reset_mid;
        logic [7:0] b = 8'h81;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++)
            bit_out(b[i]);
        rx = b[4];
        clks(CPB / 2);
        n_checks++;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %0b, expected 1", o_busy); end
        rst = 1'b1;
        rx  = 1'b1;
        clks(1);
        rst = 1'b0;
        n_checks += 3;
        if (o_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %02h, expected 00", o_data); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b, expected 0", o_busy); end
        if (o_valid !== 1'b0 || o_frame_err !== 1'b0 || o_parity_err !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: got %0b%0b%0b, expected 000", o_valid, o_frame_err, o_parity_err); end
        clks(2 * CPB);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 1'b1);
        clks(20);
        n_checks += 2;
        if (o_data !== 8'h42) begin n_fail++; $display("FAIL midrst_next_data: got %02h, expected 42", o_data); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_queue: got %0d pending, expected 0", exp_q.size()); end
    endtask

`ifdef CHIRP_UART_PARITY_EN
    task automatic test_parity;
        int v0 = n_valid, f0 = n_ferr, p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b0);
        clks(20);
        n_checks += 3;
        if (n_perr !== p0 + 1) begin n_fail++; $display("FAIL parity_err_count: got %0d, expected 1", n_perr - p0); end
        if (n_valid !== v0 || n_ferr !== f0) begin n_fail++; $display("FAIL parity_bad_pulses: got v%0d f%0d, expected 0 0", n_valid - v0, n_ferr - f0); end
        if (o_data !== 8'h42) begin n_fail++; $display("FAIL parity_data_held: got %02h, expected 42", o_data); end
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        clks(20);
        n_checks += 2;
        if (o_data !== 8'h07) begin n_fail++; $display("FAIL parity_good_data: got %02h, expected 07", o_data); end
        if (n_perr !== p0 + 1) begin n_fail++; $display("FAIL parity_good_no_err: got %0d, expected 1", n_perr - p0); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid;
`ifdef CHIRP_UART_PARITY_EN
        test_parity;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
